mcycle_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit for the RISC-V execute stage, operating in parallel with the single-cycle ALU on the same forwarded operands. It implements the RV32M operations mul/mulh/mulhu and div/divu/rem/remu. It asserts a stall (`Busy`) back to the pipeline while computing and writes both result words into output registers that the writeback mux selects from.

---
 rtl/mcycle_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_mcycle_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// -----------------------------------------------------------------------------
// mcycle_unit
//   Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU
//   in the execute stage. One iteration per clock for WIDTH clocks: shift-add
//   for multiply, restoring shift-subtract for divide. Operands are reduced to
//   magnitudes on accept, and the sign is re-applied on the final iteration.
//
// Ports
//   CLK       in   clock, all state on the rising edge
//   RESET     in   synchronous active-low reset
//   Start     in   request an operation (sampled in IDLE or DONE only)
//   MCycleOp  in   [1]=1 divide / 0 multiply, [0]=1 unsigned / 0 signed
//   Operand1  in   multiplicand / dividend
//   Operand2  in   multiplier / divisor
//   Result1   out  low product word / quotient (registered)
//   Result2   out  high product word / remainder (registered)
//   Busy      out  combinational stall request to the pipeline
//   Done      out  registered one-cycle pulse, results valid
// -----------------------------------------------------------------------------
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched operation context
    logic               r_is_div;
    logic               r_neg_res;     // negate product / quotient
    logic               r_neg_rem;     // remainder follows dividend sign
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_op1_raw;     // original dividend for divide-by-zero
    logic [WIDTH-1:0]   r_mag1;
    logic [WIDTH-1:0]   r_mag2;
    logic [CW-1:0]      r_count;

    // Iteration state
    logic [2*WIDTH-1:0] r_acc;         // {partial product, remaining multiplier}
    logic [WIDTH-1:0]   r_rem;         // partial remainder (always < divisor)
    logic [WIDTH-1:0]   r_quo;         // {remaining dividend bits, quotient bits}

    logic [WIDTH-1:0]   r_result1;
    logic [WIDTH-1:0]   r_result2;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_is_signed;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res1;
    logic [WIDTH-1:0]   w_res2;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        Busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                Busy = Start;
                if (Start) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                Busy = 1'b1;
                if (r_count == LAST_ITER) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Busy drops here so the stall releases; a new Start re-asserts it.
                Busy         = Start;
                w_state_next = Start ? S_COMPUTE : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && Start;
    assign w_last   = (r_state == S_COMPUTE) && (r_count == LAST_ITER);

    // ------------------------------------------------------------------
    // Operand conditioning on accept
    // ------------------------------------------------------------------
    assign w_is_signed = ~MCycleOp[0];
    assign w_op1_neg   = w_is_signed & Operand1[WIDTH-1];
    assign w_op2_neg   = w_is_signed & Operand2[WIDTH-1];
    assign w_mag1      = w_op1_neg ? (~Operand1 + 1'b1) : Operand1;
    assign w_mag2      = w_op2_neg ? (~Operand2 + 1'b1) : Operand2;

    // ------------------------------------------------------------------
    // One iteration of each datapath
    // ------------------------------------------------------------------
    // Shift-add: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole accumulator right keeping the carry.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_acc[0] ? r_mag1 : {WIDTH{1'b0}})};
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide. The shifted partial remainder needs WIDTH+1 bits.
    // Because it is always below twice the divisor, bit WIDTH of the
    // difference is set exactly when the subtraction borrows.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mag2};
    assign w_borrow    = w_div_diff[WIDTH];
    assign w_rem_next  = w_borrow ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], ~w_borrow};

    // ------------------------------------------------------------------
    // Sign correction and special cases on the final iteration.
    // The signed overflow case (most-negative / -1) needs no special path:
    // the magnitude quotient is 2^(WIDTH-1), whose negation wraps to itself,
    // and the remainder is zero.
    // ------------------------------------------------------------------
    assign w_prod_fix = r_neg_res ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quo_fix  = r_neg_res ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_fix  = r_neg_rem ? (~w_rem_next + 1'b1) : w_rem_next;

    always_comb begin
        w_res1 = w_prod_fix[WIDTH-1:0];
        w_res2 = w_prod_fix[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_res1 = {WIDTH{1'b1}};
                w_res2 = r_op1_raw;
            end else begin
                w_res1 = w_quo_fix;
                w_res2 = w_rem_fix;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_op1_raw  <= '0;
            r_mag1     <= '0;
            r_mag2     <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_result1  <= '0;
            r_result2  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_is_div   <= MCycleOp[1];
                r_neg_res  <= w_op1_neg ^ w_op2_neg;
                r_neg_rem  <= w_op1_neg;
                r_div_zero <= (Operand2 == '0);
                r_op1_raw  <= Operand1;
                r_mag1     <= w_mag1;
                r_mag2     <= w_mag2;
                r_count    <= '0;
                r_acc      <= {{WIDTH{1'b0}}, w_mag2};
                r_rem      <= '0;
                r_quo      <= w_mag1;
            end else if (r_state == S_COMPUTE) begin
                r_count <= r_count + CW'(1);
                r_acc   <= w_acc_next;
                r_rem   <= w_rem_next;
                r_quo   <= w_quo_next;
                if (w_last) begin
                    r_result1 <= w_res1;
                    r_result2 <= w_res2;
                end
            end
        end
    end

    assign Result1 = r_result1;
    assign Result2 = r_result2;
    assign Done    = r_done;

endmodule

// File: tb/tb_mcycle_unit.sv
// -----------------------------------------------------------------------------
// tb_mcycle_unit
//   Self-checking bench for mcycle_unit. A cycle-level reference model built
//   on 64-bit arithmetic predicts Busy/Done/Result1/Result2 every cycle;
//   directed operations also pin literal results and latency.
// -----------------------------------------------------------------------------
module tb_mcycle_unit;

    localparam int W = 32;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  MCycleOp = 2'b00;
    logic [31:0] Operand1 = '0;
    logic [31:0] Operand2 = '0;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Architectural result of an RV32M op: returns {Result2, Result1}
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
        endcase
    endfunction

    // ---------------- reference model ----------------
    // m_age: 0 when idle, 1..W while computing, W+1 in the result cycle.
    int          m_age  = 0;
    bit          m_init = 1'b0;
    logic [31:0] m_r1 = '0, m_r2 = '0, m_p1 = '0, m_p2 = '0;

    always @(posedge CLK) begin
        if (!RESET) begin
            m_age  <= 0;
            m_r1   <= '0;
            m_r2   <= '0;
            m_init <= 1'b1;
        end else if (m_age == 0 || m_age == W + 1) begin
            if (Start) begin
                {m_p2, m_p1} <= ref_op(MCycleOp, Operand1, Operand2);
                m_age <= 1;
            end else begin
                m_age <= 0;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age == W) begin
                m_r1 <= m_p1;
                m_r2 <= m_p2;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_init) begin
            chk("busy", 32'(Busy), 32'((m_age == 0 || m_age == W + 1) ? Start : 1'b1));
            chk("done", 32'(Done), 32'(m_age == W + 1));
            chk("result1", Result1, m_r1);
            chk("result2", Result2, m_r2);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_noise();
        Start    = 1'($urandom);
        MCycleOp = 2'($urandom);
        Operand1 = rand_word();
        Operand2 = rand_word();
    endtask

    // Advance until Done is seen at a negedge or the cycle index reaches limit.
    task automatic wait_done(inout int n, input int limit, input bit noise);
        while (n < limit) begin
            @(negedge CLK);
            if (Done) return;
            @(posedge CLK); #1;
            n++;
            if (noise) begin
                if (n <= W) drive_noise();
                else Start = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                          input bit noise);
        int          n;
        logic [63:0] m;
        m = ref_op(op, a, b);
        chk({name, " model r1"}, m[31:0], e1);
        chk({name, " model r2"}, m[63:32], e2);
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        @(negedge CLK);
        chk({name, " busy c0"}, 32'(Busy), 32'd1);
        @(posedge CLK); #1;
        n = 1;
        if (noise) drive_noise();
        else Start = 1'b0;
        wait_done(n, 40, noise);
        chk({name, " latency"}, 32'(n), 32'd33);
        chk({name, " busy done"}, 32'(Busy), 32'd0);
        chk({name, " r1"}, Result1, e1);
        chk({name, " r2"}, Result2, e2);
        $display("op %-12s op=%0d a=%h b=%h -> r1=%h r2=%h cycles=%0d",
                 name, op, a, b, Result1, Result2, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        // Reset
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset r1", Result1, 32'd0);
        chk("reset r2", Result2, 32'd0);
        chk("reset busy", 32'(Busy), 32'd0);

        // Directed operations
        run_op("mul -7*3",  2'b00, 32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        run_op("mulu max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("mul -1*-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        run_op("div -7/2",  2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("divu 100/7",2'b11, 32'd100,       32'd7,        32'd14,        32'd2,         1'b0);
        run_op("divu x/0",  2'b11, 32'd100,       32'd0,        32'hFFFF_FFFF, 32'h0000_0064, 1'b0);
        run_op("div ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run_op("div noisy", 2'b10, 32'd1000,      32'hFFFF_FFFD, 32'hFFFF_FEB3, 32'h0000_0001, 1'b1);

        // Back-to-back: Start held through DONE
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd5; Operand2 = 32'd6;
        @(posedge CLK); #1;
        n = 1;
        MCycleOp = 2'b11; Operand1 = 32'd100; Operand2 = 32'd7;
        wait_done(n, 40, 1'b0);
        chk("b2b first latency", 32'(n), 32'd33);
        chk("b2b first r1", Result1, 32'd30);
        chk("b2b first r2", Result2, 32'd0);
        @(posedge CLK); #1;
        n++;
        Start = 1'b0;
        wait_done(n, 80, 1'b0);
        chk("b2b second latency", 32'(n), 32'd66);
        chk("b2b second r1", Result1, 32'd14);
        chk("b2b second r2", Result2, 32'd2);
        $display("op b2b        done at cycles 33 and %0d", n);

        // Reset in the middle of a divide
        @(posedge CLK); #1;
        Start = 1'b1; MCycleOp = 2'b10; Operand1 = 32'hFFFF_FFF9; Operand2 = 32'd2;
        @(posedge CLK); #1;
        Start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("midreset done", 32'(Done), 32'd0);
        chk("midreset r1", Result1, 32'd0);
        chk("midreset r2", Result2, 32'd0);
        chk("midreset busy", 32'(Busy), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done) seen++;
        end
        chk("no done after reset", 32'(seen), 32'd0);
        $display("op reset      aborted divide at cycle 10");
        run_op("after reset", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Randomized traffic, occasional single-cycle resets
        for (int c = 0; c < 4000; c++) begin
            @(posedge CLK); #1;
            Start    = ($urandom_range(0, 2) == 0);
            MCycleOp = 2'($urandom);
            Operand1 = rand_word();
            Operand2 = rand_word();
            RESET    = ($urandom_range(0, 599) != 0);
        end
        @(posedge CLK); #1;
        Start = 1'b0;
        RESET = 1'b1;
        repeat (40) @(posedge CLK);
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
